// File: rtl/uart_rx_byte_toggle.sv
// 8N1 UART receiver, LSB first. Each correctly framed byte is loaded into
// ascii_data and announced by inverting received_toggle_signal on the same edge.
module uart_rx_byte_toggle #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] ascii_data,
    output logic       received_toggle_signal,
    output logic       framing_error,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    logic [1:0]       sync_reg;
    logic             rxd_s;
    state_t           state_reg;
    logic [CNT_W-1:0] clk_cnt_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic [7:0]       ascii_data_reg;
    logic             toggle_reg;
    logic             framing_error_reg;
    logic             rx_busy_reg;

    // Two-flop synchronizer; reset to 1 so an idle line is assumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rxd};
        end
    end

    assign rxd_s = sync_reg[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            clk_cnt_reg       <= '0;
            bit_cnt_reg       <= '0;
            shift_reg         <= '0;
            ascii_data_reg    <= '0;
            toggle_reg        <= 1'b0;
            framing_error_reg <= 1'b0;
            rx_busy_reg       <= 1'b0;
        end else begin
            framing_error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!rxd_s) begin
                        state_reg   <= START;
                        clk_cnt_reg <= '0;
                        bit_cnt_reg <= '0;
                        rx_busy_reg <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt_reg == HALF_LAST) begin
                        clk_cnt_reg <= '0;
                        if (!rxd_s) begin
                            state_reg <= DATA;
                        end else begin
                            state_reg   <= IDLE;
                            rx_busy_reg <= 1'b0;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_reg <= '0;
                        shift_reg   <= {rxd_s, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_reg <= '0;
                        if (rxd_s) begin
                            // Returning at mid-stop-bit leaves half a bit to catch the next start.
                            ascii_data_reg <= shift_reg;
                            toggle_reg     <= ~toggle_reg;
                            state_reg      <= IDLE;
                            rx_busy_reg    <= 1'b0;
                        end else begin
                            framing_error_reg <= 1'b1;
                            state_reg         <= WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (rxd_s) begin
                        state_reg   <= IDLE;
                        rx_busy_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    rx_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ascii_data             = ascii_data_reg;
    assign received_toggle_signal = toggle_reg;
    assign framing_error          = framing_error_reg;
    assign rx_busy                = rx_busy_reg;

endmodule

// File: tb/tb_uart_rx_byte_toggle.sv
// Bench for uart_rx_byte_toggle: frame-level reference model of bytes, toggles
// and framing errors, plus a latency measurement on a CLKS_PER_BIT=16 instance.
module tb_uart_rx_byte_toggle;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] a8, a16;
    logic       t8, t16, fe8, fe16, b8, b16;

    always #5 clk = ~clk;

    uart_rx_byte_toggle #(.CLKS_PER_BIT(8)) dut8 (
        .clk(clk), .rst(rst), .rxd(rxd), .ascii_data(a8),
        .received_toggle_signal(t8), .framing_error(fe8), .rx_busy(b8)
    );

    uart_rx_byte_toggle #(.CLKS_PER_BIT(16)) dut16 (
        .clk(clk), .rst(rst), .rxd(rxd), .ascii_data(a16),
        .received_toggle_signal(t16), .framing_error(fe16), .rx_busy(b16)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: what the consumer should see on dut8.
    logic [7:0] exp_data = 8'h00;
    logic       exp_tog  = 1'b0;

    // Monitor of dut8 activity.
    int         tog_changes = 0;
    int         fe_pulses   = 0;
    int         fe_max      = 0;
    int         fe_run      = 0;
    logic       prev_tog    = 1'b0;
    logic [7:0] got[$];

    always @(negedge clk) begin
        if (t8 !== prev_tog) begin
            tog_changes++;
            got.push_back(a8);
        end
        prev_tog = t8;
        if (fe8 === 1'b1) begin
            fe_run++;
        end else begin
            if (fe_run > 0) begin
                fe_pulses++;
                if (fe_run > fe_max) fe_max = fe_run;
            end
            fe_run = 0;
        end
    end

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int cpb);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (cpb) @(posedge clk);
            #1;
        end
    endtask

    // Compare dut8 outputs against the model after a frame.
    task automatic check_outputs(input string tag);
        n_checks++;
        if (a8 !== exp_data) $display("FAIL %s ascii_data: got %02h expected %02h", tag, a8, exp_data);
        else n_pass++;
        n_checks++;
        if (t8 !== exp_tog) $display("FAIL %s toggle: got %b expected %b", tag, t8, exp_tog);
        else n_pass++;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        idle(4);
        n_checks++;
        if ({a8, t8, fe8, b8} !== 11'd0)
            $display("FAIL reset_vals: got data=%02h tog=%b fe=%b busy=%b expected all 0", a8, t8, fe8, b8);
        else n_pass++;
        rst = 1'b0;
        idle(4);
        prev_tog = t8;
        check_outputs("reset");
        $display("test_reset: data=%02h tog=%b busy=%b", a8, t8, b8);
    endtask

    task automatic test_single();
        int tc0, fp0;
        tc0 = tog_changes; fp0 = fe_pulses;
        send_frame(8'h41, 1'b1, 8);
        idle(4);
        exp_data = 8'h41; exp_tog = ~exp_tog;
        check_outputs("single");
        n_checks++;
        if (tog_changes - tc0 != 1) $display("FAIL single_changes: got %0d expected 1", tog_changes - tc0);
        else n_pass++;
        n_checks++;
        if (fe_pulses != fp0) $display("FAIL single_fe: got %0d pulses expected 0", fe_pulses - fp0);
        else n_pass++;
        n_checks++;
        if (b8 !== 1'b0) $display("FAIL single_busy: got %b expected 0", b8);
        else n_pass++;
        $display("test_single: sent 41 got data=%02h tog=%b", a8, t8);
    endtask

    task automatic test_back_to_back();
        int tc0;
        tc0 = tog_changes;
        got.delete();
        send_frame(8'h66, 1'b1, 8);
        send_frame(8'h39, 1'b1, 8);
        idle(4);
        exp_data = 8'h39;
        n_checks++;
        if (tog_changes - tc0 != 2) $display("FAIL b2b_changes: got %0d expected 2", tog_changes - tc0);
        else n_pass++;
        n_checks++;
        if (got.size() < 1 || got[0] !== 8'h66)
            $display("FAIL b2b_first: got %02h expected 66", got.size() > 0 ? got[0] : 8'hxx);
        else n_pass++;
        check_outputs("b2b");
        $display("test_back_to_back: sent 66 39 got data=%02h tog=%b changes=%0d", a8, t8, tog_changes - tc0);
    endtask

    task automatic test_glitch();
        int tc0;
        tc0 = tog_changes;
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(16);
        n_checks++;
        if (tog_changes != tc0) $display("FAIL glitch_changes: got %0d expected 0", tog_changes - tc0);
        else n_pass++;
        n_checks++;
        if (b8 !== 1'b0) $display("FAIL glitch_busy: got %b expected 0", b8);
        else n_pass++;
        check_outputs("glitch");
        send_frame(8'h30, 1'b1, 8);
        idle(4);
        exp_data = 8'h30; exp_tog = ~exp_tog;
        check_outputs("after_glitch");
        $display("test_glitch: then sent 30 got data=%02h tog=%b", a8, t8);
    endtask

    task automatic test_framing();
        int tc0, fp0;
        tc0 = tog_changes; fp0 = fe_pulses; fe_max = 0;
        send_frame(8'h35, 1'b0, 8);
        rxd = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        n_checks++;
        if (b8 !== 1'b1) $display("FAIL framing_busy_low: got %b expected 1", b8);
        else n_pass++;
        n_checks++;
        if (fe_pulses - fp0 != 1) $display("FAIL framing_pulses: got %0d expected 1", fe_pulses - fp0);
        else n_pass++;
        n_checks++;
        if (fe_max != 1) $display("FAIL framing_width: got %0d expected 1", fe_max);
        else n_pass++;
        n_checks++;
        if (tog_changes != tc0) $display("FAIL framing_changes: got %0d expected 0", tog_changes - tc0);
        else n_pass++;
        check_outputs("framing");
        idle(8);
        n_checks++;
        if (b8 !== 1'b0) $display("FAIL framing_busy_idle: got %b expected 0", b8);
        else n_pass++;
        send_frame(8'h62, 1'b1, 8);
        idle(4);
        exp_data = 8'h62; exp_tog = ~exp_tog;
        check_outputs("after_framing");
        $display("test_framing: fe_pulses=%0d then sent 62 got data=%02h tog=%b", fe_pulses - fp0, a8, t8);
    endtask

    task automatic test_mid_reset();
        fork
            send_frame(8'h43, 1'b1, 8);
            begin
                repeat (36) @(posedge clk);
                #1;
                rst = 1'b1;
                repeat (50) @(posedge clk);
                #1;
            end
        join
        rst = 1'b0;
        exp_data = 8'h00; exp_tog = 1'b0;
        n_checks++;
        if ({fe8, b8} !== 2'b00) $display("FAIL midreset_flags: got fe=%b busy=%b expected 0 0", fe8, b8);
        else n_pass++;
        check_outputs("midreset");
        idle(8);
        prev_tog = t8;
        send_frame(8'h44, 1'b1, 8);
        idle(4);
        exp_data = 8'h44; exp_tog = 1'b1;
        check_outputs("after_midreset");
        $display("test_mid_reset: then sent 44 got data=%02h tog=%b", a8, t8);
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit         stop_bit;
        int         gap, tc0, fp0;
        for (int k = 0; k < 24; k++) begin
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 4) != 0);
            gap      = stop_bit ? $urandom_range(0, 2) : $urandom_range(1, 2);
            tc0 = tog_changes; fp0 = fe_pulses;
            send_frame(b, stop_bit, 8);
            if (stop_bit) begin
                exp_data = b; exp_tog = ~exp_tog;
            end
            idle(gap * 8);
            if (gap > 0) begin
                n_checks++;
                if (fe_pulses - fp0 != (stop_bit ? 0 : 1))
                    $display("FAIL rand%0d_fe: got %0d pulses expected %0d", k, fe_pulses - fp0, stop_bit ? 0 : 1);
                else n_pass++;
            end
            n_checks++;
            if (tog_changes - tc0 != (stop_bit ? 1 : 0))
                $display("FAIL rand%0d_changes: got %0d expected %0d", k, tog_changes - tc0, stop_bit ? 1 : 0);
            else n_pass++;
            check_outputs($sformatf("rand%0d", k));
            $display("test_random[%0d]: sent %02h stop=%b gap=%0d got data=%02h tog=%b", k, b, stop_bit, gap, a8, t8);
        end
        idle(16);
    endtask

    task automatic test_latency();
        logic t0;
        int   n;
        bit   seen;
        rst = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(20);
        t0 = t16;
        n = 0;
        seen = 0;
        fork
            send_frame(8'hA5, 1'b1, 16);
            begin
                while (!seen && n < 400) begin
                    @(posedge clk);
                    #1;
                    n++;
                    if (t16 !== t0) seen = 1;
                end
            end
        join
        idle(4);
        n_checks++;
        if (!seen || n < 153 || n > 155)
            $display("FAIL latency: got %0d cycles (seen=%0d) expected 154 +-1", n, seen);
        else n_pass++;
        n_checks++;
        if (a16 !== 8'hA5 || t16 !== 1'b1) $display("FAIL latency_data: got %02h tog=%b expected a5 tog=1", a16, t16);
        else n_pass++;
        $display("test_latency: A5 toggle after %0d cycles data=%02h", n, a16);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_mid_reset();
        test_random();
        test_latency();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte_toggle.md
Name: uart_rx_byte_toggle

Overview:
UART receiver (8N1, LSB first) that recovers bytes from the serial line and presents each one as an 8-bit ASCII code with a toggle-style "new byte" indication. It sits directly upstream of the ASCII-to-hex decode stage. That stage detects a change in the toggle and latches the byte. The toggle scheme keeps the interface free of pulse-width or handshake constraints.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200). Legal range: >= 4. Counter width is $clog2(CLKS_PER_BIT).

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
rxd  input  1  asynchronous serial line; idle high
ascii_data  output  8  last correctly framed byte received
received_toggle_signal  output  1  inverts once per correctly framed byte
framing_error  output  1  one-cycle pulse when the stop bit samples low
rx_busy  output  1  high while in any state other than IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - ascii_data=0x00, received_toggle_signal=0, framing_error=0, rx_busy=0.
  - State=IDLE; counters and shift register cleared.
  - Synchronizer flops set to 1 (line idle).
  - Reset asserted mid-frame abandons the frame with no output change beyond the reset values.
- Input synchronization: rxd passes through a 2-flop synchronizer (rxd_s). All sampling uses rxd_s, which adds 2 cycles of fixed latency.
- States:
  - IDLE: wait for rxd_s=0 → START, clear bit counter.
  - START: count CLKS_PER_BIT/2 (integer division) cycles, then sample rxd_s.
    - 0 → DATA, counter cleared.
    - 1 → IDLE (glitch rejected; no outputs change).
  - DATA: every CLKS_PER_BIT cycles, sample rxd_s into shift register, LSB first. After the 8th sample → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxd_s.
    - 1 → on that same edge, load ascii_data with the shift register, invert received_toggle_signal, go to IDLE.
    - 0 → framing_error=1 for exactly one cycle; ascii_data and toggle unchanged; go to WAIT_IDLE.
  - WAIT_IDLE: remain until rxd_s=1, then → IDLE. This prevents a break or low line from being decoded as a stream of 0x00 bytes.
- ascii_data and received_toggle_signal update on the same edge, so the consumer always sees the data valid when the toggle changes. ascii_data holds its value between frames.
- Sampling point is mid-bit. Latency from the rxd start-bit falling edge to the toggle change is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles, ±1.
- Back-to-back frames: return to IDLE happens at mid-stop-bit, so a start bit immediately following the stop bit is detected with no lost frame.
- Byte value is not checked; any 8-bit value (including non-hex ASCII) is passed through unchanged.
- Arbitrary line noise never produces X on outputs; no other error reporting beyond framing_error.

Test Plan:
- CLKS_PER_BIT=8; reset, then send 0x41 ('A') → after the stop bit, ascii_data=0x41, toggle 0→1, framing_error stays 0, rx_busy low again.
- Send 0x66 then 0x39 back-to-back with no idle gap → ascii_data=0x66 with toggle→0, then ascii_data=0x39 with toggle→1. Exactly two toggle changes.
- Drive rxd low for 2 cycles (less than CLKS_PER_BIT/2), then high → returns to IDLE; ascii_data and toggle unchanged; next valid frame 0x30 is received correctly.
- Send 0x35 with stop bit=0, holding rxd low 3 more bit times → single-cycle framing_error; ascii_data/toggle unchanged; no further bytes while low. After rxd goes high, 0x62 is received normally.
- Assert rst during the 4th data bit of 0x43 → outputs go to reset values; the remainder of that frame produces no toggle; next frame 0x44 gives ascii_data=0x44, toggle=1.
- Measure latency with CLKS_PER_BIT=16 for byte 0xA5 → toggle changes 2+8+144 cycles (±1) after the start-bit falling edge on rxd.
